fetch_stage: RTL and testbench



---
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// Requests are single-cycle pulses that are always accepted; responses return later on rvalid.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage plus IF/ID register: keeps at most one imem request in flight and
// parks one returned instruction in a hold buffer while decode is stalled.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          StallF,
    input  logic          StallD,
    input  logic          FlushD,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    fetch_stage_if.master imem,
    output logic [31:0]   instr_D,
    output logic [31:0]   pc_D,
    output logic          valid_D
);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t      state;
    logic [31:0] pc_f;
    logic [31:0] req_pc;
    logic        hold_valid;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;

    logic        accept;
    logic        hold_next;
    logic        hold_load;
    logic        issue;

    // A new request may only go out when nothing stays in flight and the hold buffer ends up
    // empty, which is what keeps the one-entry hold buffer from ever overflowing.
    always_comb begin
        accept    = (state == WAIT) && imem.imem_rvalid && !redirect_valid;
        hold_next = hold_valid;
        hold_load = 1'b0;
        if (redirect_valid) begin
            hold_next = 1'b0;
        end else if (FlushD) begin
            hold_next = hold_valid;
        end else if (StallD) begin
            hold_next = hold_valid || accept;
            hold_load = accept && !hold_valid;
        end else begin
            hold_next = hold_valid && accept;
            hold_load = hold_valid && accept;
        end
        issue = !StallF && !redirect_valid && !hold_next &&
                ((state == IDLE) || ((state == WAIT) && imem.imem_rvalid));
    end

    assign imem.imem_req  = issue && i_rst_n;
    assign imem.imem_addr = pc_f;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            pc_f       <= RESET_PC;
            req_pc     <= RESET_PC;
            hold_valid <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc    <= 32'd0;
            instr_D    <= NOP_INSTR;
            pc_D       <= 32'd0;
            valid_D    <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc_f <= {redirect_pc[31:2], 2'b00};
            end else if (issue) begin
                pc_f <= pc_f + 32'd4;
            end
            if (issue) begin
                req_pc <= pc_f;
            end

            // A redirect with nothing returned yet leaves a stale response in flight; DROP eats it.
            case (state)
                IDLE: if (issue) state <= WAIT;
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        state <= issue ? WAIT : IDLE;
                    end else if (redirect_valid) begin
                        state <= DROP;
                    end
                end
                DROP: if (imem.imem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase

            hold_valid <= hold_next;
            if (hold_load) begin
                hold_instr <= imem.imem_rdata;
                hold_pc    <= req_pc;
            end

            if (FlushD) begin
                instr_D <= NOP_INSTR;
                valid_D <= 1'b0;
            end else if (!StallD) begin
                if (hold_valid) begin
                    instr_D <= hold_instr;
                    pc_D    <= hold_pc;
                    valid_D <= 1'b1;
                end else if (accept) begin
                    instr_D <= imem.imem_rdata;
                    pc_D    <= req_pc;
                    valid_D <= 1'b1;
                end else begin
                    instr_D <= NOP_INSTR;
                    valid_D <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a variable-latency memory model that returns the request
// address as the instruction, plus per-scenario tasks with hand-computed expectations.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk;
    logic        i_rst_n;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic        valid_D;

    int n_vec = 0;
    int n_err = 0;

    fetch_stage_if imem();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .StallF        (StallF),
        .StallD        (StallD),
        .FlushD        (FlushD),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem          (imem),
        .instr_D       (instr_D),
        .pc_D          (pc_D),
        .valid_D       (valid_D)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          mem_lat  = 1;
    int          mem_cnt  = 0;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_a    = 32'd0;
    logic        mem_rv   = 1'b0;
    logic [31:0] mem_rd   = 32'd0;
    logic        req_s;
    logic [31:0] addr_s;
    logic        inj_rv   = 1'b0;
    logic [31:0] inj_rd   = 32'd0;

    assign imem.imem_rvalid = mem_rv | inj_rv;
    assign imem.imem_rdata  = inj_rv ? inj_rd : mem_rd;

    // Memory answers mem_lat cycles after the request cycle, updating just after the edge.
    always begin
        @(posedge i_clk);
        req_s  = imem.imem_req;
        addr_s = imem.imem_addr;
        #1;
        mem_rv = 1'b0;
        if (!i_rst_n) begin
            mem_busy = 1'b0;
        end else begin
            if (req_s) begin
                mem_busy = 1'b1;
                mem_cnt  = mem_lat;
                mem_a    = addr_s;
            end
            if (mem_busy) begin
                mem_cnt = mem_cnt - 1;
                if (mem_cnt == 0) begin
                    mem_rv   = 1'b1;
                    mem_rd   = mem_a;
                    mem_busy = 1'b0;
                end
            end
        end
    end

    task automatic reset_dut(input int lat);
        @(negedge i_clk);
        i_rst_n        = 1'b0;
        StallF         = 1'b0;
        StallD         = 1'b0;
        FlushD         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        inj_rv         = 1'b0;
        mem_lat        = lat;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        i_rst_n        = 1'b0;
        StallF         = 1'b0;
        StallD         = 1'b0;
        FlushD         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        @(negedge i_clk);
        #1;
        n_vec++; if (imem.imem_req !== 1'b0) begin n_err++; $display("[TB] FAIL reset_req: got %b want 0", imem.imem_req); end
        n_vec++; if (imem.imem_addr !== 32'd0) begin n_err++; $display("[TB] FAIL reset_addr: got %h want 00000000", imem.imem_addr); end
        n_vec++; if (valid_D !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %b want 0", valid_D); end
        n_vec++; if (instr_D !== NOP) begin n_err++; $display("[TB] FAIL reset_instr: got %h want %h", instr_D, NOP); end
        n_vec++; if (pc_D !== 32'd0) begin n_err++; $display("[TB] FAIL reset_pc: got %h want 00000000", pc_D); end
    endtask

    task automatic test_stream();
        reset_dut(1);
        n_vec++; if (imem.imem_req !== 1'b1) begin n_err++; $display("[TB] FAIL stream_req0: got %b want 1", imem.imem_req); end
        n_vec++; if (imem.imem_addr !== 32'd0) begin n_err++; $display("[TB] FAIL stream_addr0: got %h want 00000000", imem.imem_addr); end
        @(negedge i_clk); #1;
        n_vec++; if (imem.imem_addr !== 32'd4) begin n_err++; $display("[TB] FAIL stream_addr1: got %h want 00000004", imem.imem_addr); end
        n_vec++; if (valid_D !== 1'b0) begin n_err++; $display("[TB] FAIL stream_valid1: got %b want 0", valid_D); end
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk); #1;
            n_vec++; if (valid_D !== 1'b1) begin n_err++; $display("[TB] FAIL stream_valid i=%0d: got %b want 1", i, valid_D); end
            n_vec++; if (pc_D !== 32'(i * 4)) begin n_err++; $display("[TB] FAIL stream_pc i=%0d: got %h want %h", i, pc_D, 32'(i * 4)); end
            n_vec++; if (instr_D !== 32'(i * 4)) begin n_err++; $display("[TB] FAIL stream_instr i=%0d: got %h want %h", i, instr_D, 32'(i * 4)); end
            n_vec++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'(i * 4 + 8)) begin
                n_err++; $display("[TB] FAIL stream_issue i=%0d: got req=%b addr=%h want req=1 addr=%h", i, imem.imem_req, imem.imem_addr, 32'(i * 4 + 8));
            end
        end
    endtask

    task automatic test_latency();
        logic exp_req;
        logic exp_valid;
        reset_dut(3);
        for (int c = 1; c <= 9; c++) begin
            @(negedge i_clk); #1;
            exp_req   = (c % 3 == 0);
            exp_valid = (c % 3 == 1) && (c > 1);
            n_vec++; if (imem.imem_req !== exp_req) begin n_err++; $display("[TB] FAIL lat3_req c=%0d: got %b want %b", c, imem.imem_req, exp_req); end
            n_vec++; if (valid_D !== exp_valid) begin n_err++; $display("[TB] FAIL lat3_valid c=%0d: got %b want %b", c, valid_D, exp_valid); end
            if (exp_valid) begin
                n_vec++; if (pc_D !== 32'(4 * ((c - 4) / 3))) begin n_err++; $display("[TB] FAIL lat3_pc c=%0d: got %h want %h", c, pc_D, 32'(4 * ((c - 4) / 3))); end
            end
            if (exp_req) begin
                n_vec++; if (imem.imem_addr !== 32'(4 * (c / 3))) begin n_err++; $display("[TB] FAIL lat3_addr c=%0d: got %h want %h", c, imem.imem_addr, 32'(4 * (c / 3))); end
            end
        end
    endtask

    task automatic test_stall_hold();
        reset_dut(1);
        @(negedge i_clk);
        @(negedge i_clk);
        @(negedge i_clk);
        StallD = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(negedge i_clk); #1;
            end
            n_vec++; if (pc_D !== 32'h4 || valid_D !== 1'b1) begin n_err++; $display("[TB] FAIL stall_hold k=%0d: got pc=%h valid=%b want pc=00000004 valid=1", k, pc_D, valid_D); end
            n_vec++; if (imem.imem_req !== 1'b0) begin n_err++; $display("[TB] FAIL stall_noreq k=%0d: got %b want 0", k, imem.imem_req); end
        end
        @(negedge i_clk);
        StallD = 1'b0;
        #1;
        n_vec++; if (pc_D !== 32'h4) begin n_err++; $display("[TB] FAIL stall_last: got %h want 00000004", pc_D); end
        n_vec++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'hC) begin n_err++; $display("[TB] FAIL stall_resume: got req=%b addr=%h want req=1 addr=0000000c", imem.imem_req, imem.imem_addr); end
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk); #1;
            n_vec++; if (valid_D !== 1'b1 || pc_D !== 32'(8 + 4 * k) || instr_D !== 32'(8 + 4 * k)) begin
                n_err++; $display("[TB] FAIL stall_drain k=%0d: got valid=%b pc=%h instr=%h want valid=1 pc=instr=%h", k, valid_D, pc_D, instr_D, 32'(8 + 4 * k));
            end
        end
    endtask

    task automatic test_redirect();
        reset_dut(2);
        for (int c = 1; c <= 8; c++) begin
            @(negedge i_clk);
        end
        #1;
        n_vec++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h10) begin n_err++; $display("[TB] FAIL redir_pre: got req=%b addr=%h want req=1 addr=00000010", imem.imem_req, imem.imem_addr); end
        @(negedge i_clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        n_vec++; if (imem.imem_req !== 1'b0) begin n_err++; $display("[TB] FAIL redir_noreq: got %b want 0", imem.imem_req); end
        n_vec++; if (pc_D !== 32'hC || valid_D !== 1'b1) begin n_err++; $display("[TB] FAIL redir_ifid: got pc=%h valid=%b want pc=0000000c valid=1", pc_D, valid_D); end
        @(negedge i_clk);
        redirect_valid = 1'b0;
        #1;
        n_vec++; if (imem.imem_req !== 1'b0) begin n_err++; $display("[TB] FAIL redir_drop_req: got %b want 0", imem.imem_req); end
        n_vec++; if (valid_D !== 1'b0) begin n_err++; $display("[TB] FAIL redir_bubble: got %b want 0", valid_D); end
        @(negedge i_clk); #1;
        n_vec++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h100) begin n_err++; $display("[TB] FAIL redir_target: got req=%b addr=%h want req=1 addr=00000100", imem.imem_req, imem.imem_addr); end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(negedge i_clk); #1;
            end
            n_vec++; if (valid_D !== 1'b0) begin n_err++; $display("[TB] FAIL redir_gap k=%0d: got valid=%b pc=%h want valid=0", k, valid_D, pc_D); end
        end
        @(negedge i_clk); #1;
        n_vec++; if (valid_D !== 1'b1 || pc_D !== 32'h100 || instr_D !== 32'h100) begin
            n_err++; $display("[TB] FAIL redir_first: got valid=%b pc=%h instr=%h want valid=1 pc=instr=00000100", valid_D, pc_D, instr_D);
        end
    endtask

    task automatic test_wrap();
        reset_dut(1);
        @(negedge i_clk);
        @(negedge i_clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        #1;
        n_vec++; if (imem.imem_req !== 1'b0) begin n_err++; $display("[TB] FAIL wrap_noreq: got %b want 0", imem.imem_req); end
        @(negedge i_clk);
        redirect_valid = 1'b0;
        #1;
        n_vec++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("[TB] FAIL wrap_addr_top: got req=%b addr=%h want req=1 addr=fffffffc", imem.imem_req, imem.imem_addr); end
        n_vec++; if (valid_D !== 1'b0) begin n_err++; $display("[TB] FAIL wrap_discard: got %b want 0", valid_D); end
        @(negedge i_clk); #1;
        n_vec++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin n_err++; $display("[TB] FAIL wrap_addr_zero: got req=%b addr=%h want req=1 addr=00000000", imem.imem_req, imem.imem_addr); end
        @(negedge i_clk); #1;
        n_vec++; if (valid_D !== 1'b1 || pc_D !== 32'hFFFF_FFFC || instr_D !== 32'hFFFF_FFFC) begin
            n_err++; $display("[TB] FAIL wrap_top: got valid=%b pc=%h instr=%h want valid=1 pc=instr=fffffffc", valid_D, pc_D, instr_D);
        end
        @(negedge i_clk); #1;
        n_vec++; if (valid_D !== 1'b1 || pc_D !== 32'h0) begin n_err++; $display("[TB] FAIL wrap_zero: got valid=%b pc=%h want valid=1 pc=00000000", valid_D, pc_D); end
    endtask

    task automatic test_flush_stall();
        reset_dut(1);
        @(negedge i_clk);
        @(negedge i_clk);
        @(negedge i_clk);
        FlushD = 1'b1;
        StallD = 1'b1;
        #1;
        n_vec++; if (pc_D !== 32'h4 || valid_D !== 1'b1) begin n_err++; $display("[TB] FAIL flush_pre: got pc=%h valid=%b want pc=00000004 valid=1", pc_D, valid_D); end
        @(negedge i_clk);
        FlushD = 1'b0;
        StallD = 1'b0;
        #1;
        n_vec++; if (valid_D !== 1'b0) begin n_err++; $display("[TB] FAIL flush_valid: got %b want 0", valid_D); end
        n_vec++; if (instr_D !== NOP) begin n_err++; $display("[TB] FAIL flush_instr: got %h want %h", instr_D, NOP); end
        @(negedge i_clk); #1;
        n_vec++; if (valid_D !== 1'b1 || pc_D !== 32'hC || instr_D !== 32'hC) begin
            n_err++; $display("[TB] FAIL flush_next: got valid=%b pc=%h instr=%h want valid=1 pc=instr=0000000c", valid_D, pc_D, instr_D);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut(3);
        @(negedge i_clk);
        StallF  = 1'b1;
        i_rst_n = 1'b0;
        #1;
        n_vec++; if (imem.imem_req !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_req: got %b want 0", imem.imem_req); end
        n_vec++; if (imem.imem_addr !== 32'd0) begin n_err++; $display("[TB] FAIL midrst_pc: got %h want 00000000", imem.imem_addr); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        inj_rv  = 1'b1;
        inj_rd  = 32'hBAD0_BAD0;
        #1;
        n_vec++; if (imem.imem_req !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_stallf: got %b want 0", imem.imem_req); end
        @(negedge i_clk);
        inj_rv = 1'b0;
        StallF = 1'b0;
        #1;
        n_vec++; if (valid_D !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_stale: got valid=%b instr=%h want valid=0", valid_D, instr_D); end
        n_vec++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'd0) begin n_err++; $display("[TB] FAIL midrst_first: got req=%b addr=%h want req=1 addr=00000000", imem.imem_req, imem.imem_addr); end
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk); #1;
            n_vec++; if (valid_D !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_wait k=%0d: got %b want 0", k, valid_D); end
        end
        @(negedge i_clk); #1;
        n_vec++; if (valid_D !== 1'b1 || pc_D !== 32'd0 || instr_D !== 32'd0) begin
            n_err++; $display("[TB] FAIL midrst_resp: got valid=%b pc=%h instr=%h want valid=1 pc=instr=00000000", valid_D, pc_D, instr_D);
        end
    endtask

    initial begin
        i_rst_n        = 1'b1;
        StallF         = 1'b0;
        StallD         = 1'b0;
        FlushD         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        test_reset();
        test_stream();
        test_latency();
        test_stall_hold();
        test_redirect();
        test_wrap();
        test_flush_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
